// File: rtl/seq_detector_if.sv
// Serial-in pattern detector bus: sample stream in, match flags/count and
// the detector's progress state out.
interface seq_detector_if #(
  parameter int PATTERN_WIDTH = 4,
  parameter int COUNT_WIDTH   = 8
);
  localparam int SW = $clog2(PATTERN_WIDTH);

  // en qualifies a: a bit is consumed only in cycles where en=1. There is
  // no backpressure; the detector accepts every enabled bit.
  logic                   en;
  logic                   a;
  logic                   y;
  logic                   y_q;
  logic [COUNT_WIDTH-1:0] match_count;
  logic                   count_sat;
  logic [SW-1:0]          progress;

  modport master (
    output en, a,
    input  y, y_q, match_count, count_sat, progress
  );

  modport slave (
    input  en, a,
    output y, y_q, match_count, count_sat, progress
  );
endinterface

// File: rtl/seq_detector.sv
// Mealy serial pattern detector with KMP-style fallback table built at
// elaboration, registered match flag and saturating match counter.
module seq_detector #(
  parameter int                       PATTERN_WIDTH = 4,
  parameter logic [PATTERN_WIDTH-1:0] PATTERN       = 4'b1011,
  parameter bit                       OVERLAP       = 1'b1,
  parameter int                       COUNT_WIDTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  seq_detector_if.slave bus
);
  localparam int SW  = $clog2(PATTERN_WIDTH);
  localparam int TBL = 2 ** (SW + 1);

  // Next progress after consuming bit b in state k: longest suffix of
  // (matched prefix + b) that is a proper prefix of PATTERN. Out-of-range
  // states map to 0.
  function automatic int calc_next(input int k, input bit b);
    int   max_l;
    int   result;
    int   j;
    bit   found;
    bit   ok;
    logic s_bit;
    result = 0;
    found  = 1'b0;
    if (k < PATTERN_WIDTH) begin
      max_l = (k + 1 < PATTERN_WIDTH) ? k + 1 : PATTERN_WIDTH - 1;
      if (k == PATTERN_WIDTH - 1 && b == PATTERN[0] && !OVERLAP) max_l = 0;
      for (int l = max_l; l >= 1; l--) begin
        ok = 1'b1;
        for (int i = 0; i < l; i++) begin
          j     = k + 1 - l + i;
          s_bit = (j == k) ? b : PATTERN[PATTERN_WIDTH-1-j];
          if (s_bit != PATTERN[PATTERN_WIDTH-1-i]) ok = 1'b0;
        end
        if (ok && !found) begin
          result = l;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

  logic [SW-1:0]          w_next_tbl [TBL];
  logic [SW-1:0]          r_progress;
  logic                   r_y_q;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_y;
  logic                   w_in_range;
  logic                   w_sat;
  logic [SW:0]            w_idx;

  // Table index is {state, a}.
  for (genvar g = 0; g < TBL; g++) begin : g_tbl
    localparam int NXT = calc_next(g / 2, (g % 2) == 1);
    assign w_next_tbl[g] = SW'(NXT);
  end

  assign w_idx      = {r_progress, bus.a};
  assign w_in_range = (r_progress <= SW'(PATTERN_WIDTH - 1));
  assign w_y        = bus.en & (r_progress == SW'(PATTERN_WIDTH - 1))
                    & (bus.a == PATTERN[0]);
  assign w_sat      = &r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_progress <= '0;
      r_y_q      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_y_q <= w_y;
      if (!w_in_range) begin
        r_progress <= '0;
      end else if (bus.en) begin
        r_progress <= w_next_tbl[w_idx];
      end
      if (w_y && !w_sat) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign bus.y           = w_y;
  assign bus.y_q         = r_y_q;
  assign bus.match_count = r_count;
  assign bus.count_sat   = w_sat;
  assign bus.progress    = r_progress;
endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter PATTERN_WIDTH, default 4, number of bits in the detected pattern; legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011, PATTERN_WIDTH-bit pattern; bit [PATTERN_WIDTH-1] is expected first.
REQ-003 Parameter OVERLAP, default 1, 1 = overlapping matches allowed, 0 = detector restarts after each match.
REQ-004 Parameter COUNT_WIDTH, default 8, width of the match counter; legal range 1..32.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  sample enable; `a` is consumed only in cycles with en=1.
REQ-008 a  input  1  serial data bit.
REQ-009 y  output  1  Mealy match flag, combinational from current state, a and en.
REQ-010 y_q  output  1  y registered; one-cycle-delayed copy of y.
REQ-011 match_count  output  COUNT_WIDTH  number of matches since reset, saturating.
REQ-012 count_sat  output  1  high while match_count equals all ones.

Function
REQ-013 The state register `progress` SHALL hold 0..PATTERN_WIDTH-1, the number of leading pattern bits currently matched.
REQ-014 The expected bit in state k SHALL be PATTERN[PATTERN_WIDTH-1-k].
REQ-015 y SHALL equal en & (progress == PATTERN_WIDTH-1) & (a == PATTERN[0]), with no register in the path from a or en to y.
REQ-016 With en=0, progress, y_q-source logic and match_count SHALL hold, and y SHALL be 0.
REQ-017 With en=1 and a equal to the expected bit and no full match, progress SHALL increment by 1.
REQ-018 With en=1 and a mismatching, progress SHALL become the length of the longest suffix of (matched prefix followed by a) that is a proper prefix of PATTERN; 0 if none.
REQ-019 On a full match (y=1), the next progress SHALL be the length of the longest proper border of PATTERN if OVERLAP=1, else 0.
REQ-020 Fallback targets of REQ-018/019 SHALL be computed at elaboration from the parameters; no runtime search loops.
REQ-021 y_q SHALL be registered from y every clock regardless of en.
REQ-022 match_count SHALL increment by 1 on every cycle with y=1 and SHALL not wrap; at all ones it holds.
REQ-023 count_sat SHALL be a registered or decoded flag equal to (match_count == 2^COUNT_WIDTH-1).
REQ-024 Any progress value outside 0..PATTERN_WIDTH-1 SHALL transition to 0 on the next clock.

Reset
REQ-025 reset=1 at a rising clk edge SHALL set progress=0, y_q=0, match_count=0, count_sat=0, and SHALL take priority over en.
REQ-026 While reset=1, y SHALL still follow REQ-015 from the current state; no match is counted in a reset cycle.
REQ-027 Reset asserted mid-pattern SHALL discard all partial progress; detection restarts from state 0 on the first enabled cycle after reset deasserts.

Verification
REQ-028 Defaults, OVERLAP=1, en=1, a=1,0,1,1,0,1,1 -> y=1 on 4th and 7th bit only, match_count=2, y_q pulses one cycle after each y.
REQ-029 Same stream with OVERLAP=0 -> y=1 on 4th bit only, match_count=1, progress=1 after the 7th bit.
REQ-030 Defaults, stream 1,0,1,1 with en=0 inserted for 3 cycles between each bit -> y=0 during gaps, single match on 4th enabled bit, match_count=1.
REQ-031 COUNT_WIDTH=2, stream of 5 back-to-back matches (OVERLAP=1, 1,0,1,1,0,1,1,0,1,1,...) -> match_count 1,2,3,3,3, count_sat=1 from the 3rd match onward.
REQ-032 Defaults, a=1,0,1, reset pulse for 1 cycle, then a=1 -> y=0, progress=1; continuing 0,1,1 -> match at the 4th post-reset bit, match_count=1.
REQ-033 PATTERN_WIDTH=3, PATTERN=3'b000, OVERLAP=1, a=0 for 6 enabled cycles -> y=1 on cycles 3,4,5,6, match_count=4; OVERLAP=0 -> y=1 on cycles 3 and 6, match_count=2.
